// File: rtl/pattern_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pattern_sequencer_pkg
//   Shared constants for the pattern sequencer: default ring length and
//   repeat-counter width, the FSM state encoding, and the ring position used
//   as the reset/home pattern for the one-hot select.
// ----------------------------------------------------------------------------
package pattern_sequencer_pkg;

    localparam int LEN_DEF  = 11;
    localparam int REPW_DEF = 4;

    // Home position of the one-hot ring (Q[Q_HOME_IDX] = 1 after reset/load).
    localparam int Q_HOME_IDX = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pattern_sequencer_onehot_ring.sv
// ----------------------------------------------------------------------------
// pattern_sequencer_onehot_ring
//   LEN-bit one-hot rotate register. Index 0 is the home position.
//   Ports:
//     i_clk         clock, rising edge
//     i_rst         asynchronous active-high reset (ring goes home)
//     i_load0       force the home position (wins over i_adv)
//     i_adv         rotate one position: q[i+1] <= q[i], q[0] <= q[LEN-1]
//     o_q           one-hot position, [0:LEN-1]
//     o_at_end      o_q[LEN-1]
//     o_at_end_nxt  value o_q[LEN-1] will take after the coming edge
// ----------------------------------------------------------------------------
module pattern_sequencer_onehot_ring
    import pattern_sequencer_pkg::*;
#(
    parameter int LEN = LEN_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_load0,
    input  logic           i_adv,
    output logic [0:LEN-1] o_q,
    output logic           o_at_end,
    output logic           o_at_end_nxt
);

    // Position 0 is the leftmost bit of a [0:LEN-1] vector, i.e. the MSB.
    localparam logic [0:LEN-1] POS_HOME =
        {{(LEN-1){1'b0}}, 1'b1} << (LEN-1-Q_HOME_IDX);

    logic [0:LEN-1] r_q;
    logic [0:LEN-1] w_q_nxt;

    always_comb begin
        w_q_nxt = r_q;
        if (i_load0) begin
            w_q_nxt = POS_HOME;
        end else if (i_adv) begin
            w_q_nxt = {r_q[LEN-1], r_q[0:LEN-2]};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= POS_HOME;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign o_q          = r_q;
    assign o_at_end     = r_q[LEN-1];
    assign o_at_end_nxt = w_q_nxt[LEN-1];

endmodule

// File: rtl/pattern_sequencer.sv
// ----------------------------------------------------------------------------
// pattern_sequencer
//   Flow-controlled sequencer for the one-hot pattern ring feeding the
//   external pattern encoder. Advances one ring position per accepted beat
//   (valid && ready), runs reps+1 passes, then pulses done.
//   Ports:
//     CLK, RST      clock; asynchronous active-high reset
//     start         begin a sequence (IDLE only); reps latched here
//     stop          abort a running sequence (RUN only), no done pulse
//     reps          extra passes, total passes = reps+1
//     ready         downstream accepts the current beat
//     Q             one-hot position select, [0:LEN-1]
//     valid, last   beat offered / final beat of the sequence
//     busy, done    in RUN / one-cycle pulse on normal completion
//   All outputs come straight from flops.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for start, Q at home, no beat offered
//   RUN   | offering beats, Q advances on each accept
//   DONE  | single cycle with done=1, then back to IDLE
// ----------------------------------------------------------------------------
module pattern_sequencer
    import pattern_sequencer_pkg::*;
#(
    parameter int LEN  = LEN_DEF,
    parameter int REPW = REPW_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic            stop,
    input  logic [REPW-1:0] reps,
    input  logic            ready,
    output logic [0:LEN-1]  Q,
    output logic            valid,
    output logic            last,
    output logic            busy,
    output logic            done
);

    localparam logic [REPW-1:0] PASS_ONE = {{(REPW-1){1'b0}}, 1'b1};

    seq_state_t      r_state, w_state_nxt;
    logic [REPW-1:0] r_pass,  w_pass_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_last,  w_last_nxt;
    logic            r_busy,  w_busy_nxt;
    logic            r_done,  w_done_nxt;

    logic            w_load0;
    logic            w_adv;
    logic            w_accept;
    logic            w_at_end;
    logic            w_at_end_nxt;

    pattern_sequencer_onehot_ring #(
        .LEN (LEN)
    ) u_ring (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_load0      (w_load0),
        .i_adv        (w_adv),
        .o_q          (Q),
        .o_at_end     (w_at_end),
        .o_at_end_nxt (w_at_end_nxt)
    );

    // r_valid is only ever set in RUN, so it doubles as the RUN qualifier.
    assign w_accept = r_valid && ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pass_nxt  = r_pass;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_load0     = 1'b0;
        w_adv       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_pass_nxt  = reps;
                    w_load0     = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
                if (w_accept) begin
                    if (!w_at_end) begin
                        w_adv = 1'b1;
                    end else if (r_pass != '0) begin
                        // Rotating from the last position wraps to home.
                        w_adv      = 1'b1;
                        w_pass_nxt = r_pass - PASS_ONE;
                    end else begin
                        w_load0     = 1'b1;
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
                // Abort overrides any accept on the same edge; that beat
                // still counts as consumed, but nothing follows it.
                if (stop) begin
                    w_adv       = 1'b0;
                    w_load0     = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_load0     = 1'b1;
            end
        endcase

        // last is registered, so derive it from the post-edge values.
        w_last_nxt = w_valid_nxt && w_at_end_nxt && (w_pass_nxt == '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_pass  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pass  <= w_pass_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign valid = r_valid;
    assign last  = r_last;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pattern_sequencer
//   Directed bench for pattern_sequencer with the default LEN=11, REPW=4.
//   Inputs change 1 time unit after a rising edge, outputs are checked at
//   the same point, well clear of the next edge.
// ----------------------------------------------------------------------------
module tb_pattern_sequencer;

    localparam int LEN  = 11;
    localparam int REPW = 4;

    logic            CLK;
    logic            RST;
    logic            start;
    logic            stop;
    logic [REPW-1:0] reps;
    logic            ready;
    logic [0:LEN-1]  Q;
    logic            valid;
    logic            last;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;

    pattern_sequencer #(
        .LEN  (LEN),
        .REPW (REPW)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .stop  (stop),
        .reps  (reps),
        .ready (ready),
        .Q     (Q),
        .valid (valid),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:LEN-1] pos(input int k);
        logic [0:LEN-1] p;
        p    = '0;
        p[k] = 1'b1;
        return p;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".q"},     32'(Q),     32'(pos(0)));
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".last"},  32'(last),  32'd0);
        chk({tag, ".busy"},  32'(busy),  32'd0);
    endtask

    // Full sequence. rdy_mode 0: ready always 1; 1: ready alternates 1,0.
    // hold_start keeps start high throughout, so a restart from IDLE is
    // expected exactly one cycle after the done pulse.
    task automatic run_seq(input int reps_i, input int rdy_mode, input bit hold_start);
        int n_beats;
        int beat;
        int cyc;
        n_beats = LEN * (reps_i + 1);
        reps    = REPW'(reps_i);
        start   = 1'b1;
        ready   = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < n_beats && cyc < 2000) begin
            ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            chk("run.onehot", 32'($countones(Q)), 32'd1);
            chk("run.valid",  32'(valid), 32'd1);
            chk("run.busy",   32'(busy),  32'd1);
            chk("run.done",   32'(done),  32'd0);
            chk("run.q",      32'(Q),     32'(pos(beat % LEN)));
            chk("run.last",   32'(last),  32'(beat == n_beats - 1));
            if (ready) beat++;
            step();
            cyc++;
        end
        chk("run.budget", 32'(cyc < 2000), 32'd1);
        ready = 1'b0;
        chk("fin.done",   32'(done),  32'd1);
        chk_idle("fin");
        step();
        chk("post.done",  32'(done),  32'd0);
        chk_idle("post");
        if (hold_start) begin
            step();
            chk("restart.valid", 32'(valid), 32'd1);
            chk("restart.busy",  32'(busy),  32'd1);
            chk("restart.q",     32'(Q),     32'(pos(0)));
            start = 1'b0;
            stop  = 1'b1;
            step();
            stop  = 1'b0;
            chk("restart.done",  32'(done),  32'd0);
            chk_idle("restart.stop");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        reps  = '0;
        ready = 1'b0;
        step();
        step();
        chk("reset.done", 32'(done), 32'd0);
        chk_idle("reset");
        #3 RST = 1'b0;
        step();

        // stop in IDLE is ignored
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("idle.stop");

        // 11 beats, 33 beats, alternating ready
        run_seq(0, 0, 1'b0);
        run_seq(2, 0, 1'b0);
        run_seq(0, 1, 1'b0);

        // Abort on beat 5 with ready high: beat consumed, no done.
        reps  = '0;
        start = 1'b1;
        ready = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("stop.pre.q", 32'(Q), 32'(pos(b)));
            step();
        end
        chk("stop.beat5.q", 32'(Q), 32'(pos(4)));
        stop = 1'b1;
        step();
        stop  = 1'b0;
        ready = 1'b0;
        chk("stop.done", 32'(done), 32'd0);
        chk_idle("stop");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stop.nodone", 32'(done), 32'd0);
        end

        // Asynchronous reset mid-run at position 7.
        reps  = 4'd1;
        start = 1'b1;
        ready = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 7; b++) step();
        chk("arst.pre.q", 32'(Q), 32'(pos(7)));
        #3 RST = 1'b1;
        #1;
        chk("arst.done", 32'(done), 32'd0);
        chk_idle("arst");
        #1 RST = 1'b0;
        ready = 1'b0;
        step();
        chk_idle("arst.after");
        run_seq(0, 0, 1'b0);

        // start held through RUN and DONE
        run_seq(0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
